// File: rtl/message_tx_arbiter.sv
// Round-robin arbiter sharing one serial message transmitter among NREQ requesters.
// Optional watchdog abort enabled by defining MSG_ARB_WATCHDOG_EN.
module message_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int MSG_W   = 5,
  parameter int TIMEOUT = 255,
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*MSG_W-1:0] msg,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic                  busy,
  output logic [IW-1:0]         owner,
  output logic                  tx_send,
  output logic [MSG_W-1:0]      tx_message,
  input  logic                  tx_valid,
  output logic [2:0]            state_dbg
);

  // Transmitter handshake: tx_send is a one-cycle start strobe (LOAD); the
  // transmitter then holds tx_valid high while serializing, and its falling
  // edge ends the owner's transfer. No ready/backpressure on tx_send.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_BUSY  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     last;
  logic [IW-1:0]     owner_q;
  logic [MSG_W-1:0]  msg_q;
  logic [IW-1:0]     winner;
  logic              found;
  logic [MSG_W-1:0]  msg_sel;
  logic              wd_fire;

  // Search starts one past the previous winner and wraps.
  always_comb begin
    logic [IW-1:0] cand;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    msg_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == winner) msg_sel = msg[i*MSG_W +: MSG_W];
    end
  end

`ifdef MSG_ARB_WATCHDOG_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] wd_cnt;
  logic          err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= wd_fire;
      if (state == S_IDLE && found) wd_cnt <= '0;
      else if (state == S_START || state == S_BUSY) wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Compare two short of TIMEOUT so FIN lands exactly TIMEOUT cycles after LOAD.
  assign wd_fire = (state == S_START || state == S_BUSY) && (wd_cnt == CW'(TIMEOUT - 2));
  assign err     = err_q && (state == S_FIN);
`else
  assign wd_fire = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (found) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_START;
      S_START: if (wd_fire) state_nxt = S_FIN;
               else if (tx_valid) state_nxt = S_BUSY;
      S_BUSY:  if (wd_fire || !tx_valid) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      last    <= IW'(NREQ - 1);
      owner_q <= '0;
      msg_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && found) begin
        owner_q <= winner;
        last    <= winner;
        msg_q   <= msg_sel;
      end
    end
  end

  always_comb begin
    gnt  = '0;
    done = '0;
    if (state == S_LOAD) gnt[owner_q]  = 1'b1;
    if (state == S_FIN)  done[owner_q] = 1'b1;
  end

  assign busy       = (state != S_IDLE);
  assign tx_send    = (state == S_LOAD);
  assign owner      = owner_q;
  assign tx_message = msg_q;
  assign state_dbg  = state;

endmodule
